// File: rtl/leitor_jogada.sv
// leitor_jogada: scans an 8x8 occupancy sensor one row at a time and debounces
// each full-board image. It reports a single placed piece as a row/column
// pulse, and flags images in which more than one square changed.
module leitor_jogada #(
  parameter int SCAN_DIV  = 4,  // cycles each row is driven before sampling
  parameter int DEB_SCANS = 3   // identical scans needed to accept an image
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       habilitar,
  input  logic [7:0] colunasSensor,
  output logic [7:0] linhaVarredura,
  output logic [2:0] jogadaFileira,
  output logic [2:0] jogadaColuna,
  output logic       temJogada,
  output logic       erroMultiplo,
  output logic [2:0] db_estado
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEB_SCANS + 1);

  typedef enum logic [2:0] {
    INICIAL = 3'd0,
    VARRE   = 3'd1,
    COMPARA = 3'd2,
    EMITE   = 3'd3,
    ERRO    = 3'd4
  } estado_t;

  estado_t state_q, state_d;

  logic [DW-1:0] dwell_q;
  logic [2:0]    row_q;
  logic [63:0]   scan_q;   // image being assembled, row by row
  logic [63:0]   prev_q;   // image from the previous full scan
  logic [63:0]   acc_q;    // last accepted (debounced) image
  logic [63:0]   ref_q;    // board as last reported/absorbed
  logic [CW-1:0] stab_q, stab_d;
  logic          pend_q;   // accepted image waiting to be compared
  logic          first_q;  // next comparison only loads the reference
  logic [2:0]    fil_q, col_q;

  logic          row_end, scan_end, same, accept;
  logic [63:0]   new_img, diff, place;
  logic          diff_zero, diff_single;
  logic [5:0]    idx;

  assign row_end  = (dwell_q == DW'(SCAN_DIV - 1));
  assign scan_end = row_end && (row_q == 3'd7);
  // Row 7 is still on the sensor lines when the scan completes.
  assign new_img  = {colunasSensor, scan_q[55:0]};
  assign same     = (new_img == prev_q);

  // Stable counter: restart at 1 on a change, saturate at DEB_SCANS otherwise.
  always_comb begin
    stab_d = stab_q;
    if (!same)                          stab_d = CW'(1);
    else if (stab_q != CW'(DEB_SCANS))  stab_d = stab_q + CW'(1);
  end

  // Accept only on the scan where the count first reaches the threshold.
  assign accept = scan_end && (stab_d == CW'(DEB_SCANS)) &&
                  !(same && (stab_q == CW'(DEB_SCANS)));

  // Row drive, dwell counter and image assembly; runs in every FSM state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dwell_q <= '0;
      row_q   <= '0;
      scan_q  <= '0;
    end else if (row_end) begin
      dwell_q             <= '0;
      row_q               <= row_q + 3'd1;
      scan_q[row_q*8 +: 8] <= colunasSensor;
    end else begin
      dwell_q <= dwell_q + DW'(1);
    end
  end

  assign linhaVarredura = 8'b1 << row_q;

  // End-of-scan debounce and hand-off of accepted images to the FSM.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prev_q <= '0;
      stab_q <= '0;
      acc_q  <= '0;
      pend_q <= 1'b0;
    end else begin
      if (scan_end) begin
        prev_q <= new_img;
        stab_q <= stab_d;
      end
      if (accept) begin
        acc_q  <= new_img;
        pend_q <= 1'b1;
      end else if (state_q == VARRE && pend_q) begin
        pend_q <= 1'b0;
      end
    end
  end

  // Classify the change between accepted image and reference.
  assign diff        = acc_q ^ ref_q;
  assign place       = diff & acc_q;
  assign diff_zero   = (diff == '0);
  assign diff_single = !diff_zero && ((diff & (diff - 64'd1)) == '0);

  // Position of the single placed square (only meaningful when one bit is set).
  always_comb begin
    idx = '0;
    for (int i = 0; i < 64; i++)
      if (place[i]) idx = 6'(i);
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= INICIAL;
    else        state_q <= state_d;
  end

  // Next-state logic; EMITE and ERRO last exactly one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      INICIAL: state_d = VARRE;
      VARRE:   if (pend_q) state_d = COMPARA;
      COMPARA: begin
        state_d = VARRE;
        if (!first_q && !diff_zero) begin
          if (!diff_single)               state_d = ERRO;
          else if (place != '0 && habilitar) state_d = EMITE;
        end
      end
      EMITE:   state_d = VARRE;
      ERRO:    state_d = VARRE;
      default: state_d = VARRE;
    endcase
  end

  // Reference update and move-coordinate capture on leaving COMPARA.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ref_q   <= '0;
      first_q <= 1'b1;
      fil_q   <= '0;
      col_q   <= '0;
    end else if (state_q == COMPARA) begin
      ref_q   <= acc_q;
      first_q <= 1'b0;
      if (state_d == EMITE) begin
        fil_q <= idx[5:3];
        col_q <= idx[2:0];
      end
    end
  end

  assign jogadaFileira = fil_q;
  assign jogadaColuna  = col_q;
  assign temJogada     = (state_q == EMITE);
  assign erroMultiplo  = (state_q == ERRO);
  assign db_estado     = state_q;

endmodule

// File: tb/tb_leitor_jogada.sv
// Bench for leitor_jogada: a simulated board feeds the sensor lines; a
// scan-level model (history of full-board images) predicts every pulse.
module tb_leitor_jogada;
  localparam int SD = 4, DB = 3, SCAN = 8 * SD;

  logic       clock, reset, habilitar;
  logic [7:0] colunasSensor, linhaVarredura;
  logic [2:0] jogadaFileira, jogadaColuna, db_estado;
  logic       temJogada, erroMultiplo;
  logic [63:0] board;

  int ncmp = 0, nerr = 0;

  // Scan-level reference model state.
  logic [63:0] hist[$];
  logic [63:0] m_ref, m_acc;
  bit          m_first, m_pend;
  logic [2:0]  e_fil, e_col, n_fil, n_col;
  bit          x_emit, x_err, x_cmp;

  leitor_jogada #(.SCAN_DIV(SD), .DEB_SCANS(DB)) dut (
    .clock(clock), .reset(reset), .habilitar(habilitar),
    .colunasSensor(colunasSensor), .linhaVarredura(linhaVarredura),
    .jogadaFileira(jogadaFileira), .jogadaColuna(jogadaColuna),
    .temJogada(temJogada), .erroMultiplo(erroMultiplo), .db_estado(db_estado)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Physical board: the driven row's squares appear on the column lines.
  always_comb begin
    colunasSensor = '0;
    for (int r = 0; r < 8; r++)
      if (linhaVarredura[r]) colunasSensor = colunasSensor | board[8*r +: 8];
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    ncmp++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    m_ref = '0; m_acc = '0; m_first = 1'b1; m_pend = 1'b0;
    e_fil = '0; e_col = '0;
  endtask

  // One full scan with a fixed board. Called at a negedge just before row 0
  // dwell begins; returns at the negedge after the row-7 sampling edge.
  task automatic run_scan(input logic [63:0] b, input logic h);
    logic [63:0] diff;
    int n, run;
    board = b; habilitar = h;
    x_emit = 1'b0; x_err = 1'b0; x_cmp = m_pend;
    if (m_pend) begin
      diff = m_acc ^ m_ref;
      if (!m_first) begin
        n = $countones(diff);
        if (n > 1) x_err = 1'b1;
        else if (n == 1 && (diff & m_acc) != '0 && h) begin
          x_emit = 1'b1;
          for (int i = 0; i < 64; i++)
            if (diff[i]) begin n_fil = 3'(i / 8); n_col = 3'(i % 8); end
        end
      end
      m_ref = m_acc; m_first = 1'b0; m_pend = 1'b0;
    end
    for (int e = 1; e <= SCAN; e++) begin
      @(posedge clock);
      @(negedge clock);
      if (e == 2 && x_emit) begin e_fil = n_fil; e_col = n_col; end
      chk("temJogada", temJogada, 64'((e == 2) && x_emit));
      chk("erroMultiplo", erroMultiplo, 64'((e == 2) && x_err));
      chk("db_estado", db_estado,
          (e == 1) ? (x_cmp ? 64'd2 : 64'd1) :
          (e == 2) ? (x_emit ? 64'd3 : (x_err ? 64'd4 : 64'd1)) : 64'd1);
      chk("jogadaFileira", jogadaFileira, e_fil);
      chk("jogadaColuna", jogadaColuna, e_col);
    end
    // Accept when the trailing run of identical images is exactly DB long.
    hist.push_back(b);
    run = 0;
    for (int i = hist.size() - 1; i >= 0 && hist[i] == b; i--) run++;
    if (run == DB) begin m_pend = 1'b1; m_acc = b; end
  endtask

  function automatic logic [63:0] sq(input int r, input int c);
    logic [63:0] one;
    one = 64'd1;
    return one << (8 * r + c);
  endfunction

  initial begin
    logic [63:0] b;
    logic        h;
    int          mode, ns;

    model_reset();
    reset = 1'b0; board = '0; habilitar = 1'b0;
    #23;
    chk("rst_linha", linhaVarredura, 64'h01);
    chk("rst_tem", temJogada, 0);
    chk("rst_erro", erroMultiplo, 0);
    chk("rst_estado", db_estado, 0);
    chk("rst_fil", jogadaFileira, 0);
    chk("rst_col", jogadaColuna, 0);
    @(negedge clock);
    reset = 1'b1;

    // Empty board: first acceptance only loads the reference.
    b = '0;
    repeat (4) run_scan(b, 1'b1);
    // Place at (2,5).
    b = sq(2, 5);
    repeat (4) run_scan(b, 1'b1);
    // (4,1) flickers every scan: never accepted.
    repeat (5) begin
      run_scan(b | sq(4, 1), 1'b1);
      run_scan(b, 1'b1);
    end
    // Two placements in one image.
    b = b | sq(0, 0) | sq(7, 7);
    repeat (4) run_scan(b, 1'b1);
    // Placement while disabled is absorbed; enabling later stays silent.
    b = b | sq(3, 3);
    repeat (4) run_scan(b, 1'b0);
    repeat (2) run_scan(b, 1'b1);
    b = b | sq(6, 0);
    repeat (4) run_scan(b, 1'b1);
    // Lift (2,5).
    b = b & ~sq(2, 5);
    repeat (4) run_scan(b, 1'b1);

    // Reset mid-scan while row 5 is driven.
    repeat (21) @(posedge clock);
    #1;
    chk("pre_rst_linha", linhaVarredura, 64'h20);
    reset = 1'b0;
    #1;
    chk("mid_rst_linha", linhaVarredura, 64'h01);
    chk("mid_rst_tem", temJogada, 0);
    chk("mid_rst_estado", db_estado, 0);
    @(negedge clock);
    reset = 1'b1;
    model_reset();

    // Randomized episodes.
    b = '0;
    for (int ep = 0; ep < 40; ep++) begin
      mode = int'($urandom_range(0, 3));
      if (mode >= 1) b[$urandom_range(0, 63)] ^= 1'b1;
      if (mode >= 2) b[$urandom_range(0, 63)] ^= 1'b1;
      if (mode == 3 && $urandom_range(0, 1) == 1) b = b & ~sq(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
      h  = 1'($urandom_range(0, 3) != 0);
      ns = int'($urandom_range(1, 5));
      repeat (ns) run_scan(b, h);
    end
    run_scan(b, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
